// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker.
//   state_t                     : checker FSM states
//   ADDR_ID / ADDR_TS           : word addresses on the sysid slave
//   DEFAULT_EXPECTED_ID         : system ID reported by an unmodified build
//   DEFAULT_EXPECTED_TIMESTAMP  : build timestamp reported by an unmodified build
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1512962994;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
//   avm_address     : word select, 0 = system ID, 1 = timestamp
//   avm_read        : read strobe
//   avm_readdata    : read data returned by the slave
//   avm_waitrequest : slave stall; a read completes when read=1 and waitrequest=0
interface sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/sysid_checker.sv
// Reads the system ID and build timestamp words from a sysid slave and
// compares them with the values this build expects. A check runs
// automatically when reset is released and again on every accepted start.
//
// Ports
//   clock, reset : single clock, synchronous active-high reset
//   start        : one-cycle pulse requesting a re-check (ignored while busy)
//   avm          : Avalon-MM master port (address, read, readdata, waitrequest)
//   busy         : check in progress (RD_ID, RD_TS, CHECK)
//   done         : check finished, held until the next check starts
//   pass         : id_ok & ts_ok & ~timeout, valid while done=1
//   id_ok, ts_ok : per-word compare results
//   timeout      : a read stalled for longer than TIMEOUT_CYCLES
//   read_id      : captured system ID word
//   read_ts      : captured timestamp word
//
// state | meaning
// IDLE  | just out of reset; always launches the auto-check next cycle
// RD_ID | reading word 0 (system ID)
// RD_TS | reading word 1 (timestamp)
// CHECK | comparing captured words against the expected values
// FIN   | results held, done=1; start launches a re-check
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = sysid_pkg::DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = sysid_pkg::DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          TIMEOUT_CYCLES     = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  sysid_checker_if.master        avm,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout,
  output logic [31:0]            read_id,
  output logic [31:0]            read_ts
);

  import sysid_pkg::*;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= ADDR_ID;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout         <= 1'b0;
      read_id         <= 32'd0;
      read_ts         <= 32'd0;
      wait_cnt        <= 16'd0;
    end else begin
      unique case (state)
        // IDLE is only reachable through reset, so leaving it unconditionally
        // is the auto-check; FIN needs an explicit start.
        IDLE, FIN: begin
          if (state == IDLE || start) begin
            state           <= RD_ID;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_ID;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout         <= 1'b0;
            wait_cnt        <= 16'd0;
          end
        end

        RD_ID, RD_TS: begin
          if (!avm.avm_waitrequest) begin
            wait_cnt <= 16'd0;
            if (state == RD_ID) begin
              read_id         <= avm.avm_readdata;
              avm.avm_address <= ADDR_TS;
              state           <= RD_TS;
            end else begin
              read_ts      <= avm.avm_readdata;
              avm.avm_read <= 1'b0;
              state        <= CHECK;
            end
          end else if (wait_cnt == TIMEOUT_LIM) begin
            // Stalled past the limit: abandon the read and report failure.
            avm.avm_read <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            timeout      <= 1'b1;
            pass         <= 1'b0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            state        <= FIN;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        CHECK: begin
          id_ok <= (read_id == EXPECTED_ID);
          ts_ok <= (read_ts == EXPECTED_TIMESTAMP);
          pass  <= (read_id == EXPECTED_ID) && (read_ts == EXPECTED_TIMESTAMP);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end

        default: begin
          state        <= IDLE;
          avm.avm_read <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a small sysid slave model with a
// programmable number of stall cycles per read (or a stuck stall), and a
// linear sequence of checks sampled on the falling clock edge.
module tb_sysid_checker;

  logic        clock;
  logic        reset;
  logic        start;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] read_id, read_ts;

  logic [31:0] id_val;
  logic [31:0] ts_val;
  logic [7:0]  wait_n;
  logic        stuck;
  logic [7:0]  stall_ctr;

  int tests;
  int fails;

  sysid_checker_if bus ();

  sysid_checker #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (32'd1512962994),
    .TIMEOUT_CYCLES     (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .avm     (bus),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .id_ok   (id_ok),
    .ts_ok   (ts_ok),
    .timeout (timeout),
    .read_id (read_id),
    .read_ts (read_ts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model: stalls each read for wait_n cycles, or forever when stuck.
  assign bus.avm_readdata    = bus.avm_address ? ts_val : id_val;
  assign bus.avm_waitrequest = stuck | (bus.avm_read & (stall_ctr < wait_n));

  always @(posedge clock) begin
    if (reset || !bus.avm_read)
      stall_ctr <= 8'd0;
    else if (bus.avm_waitrequest)
      stall_ctr <= stall_ctr + 8'd1;
    else
      stall_ctr <= 8'd0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    id_val = 32'd0;
    ts_val = 32'd1512962994;
    wait_n = 8'd0;
    stuck  = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_read",    32'(bus.avm_read), 32'd0);
    chk("rst_addr",    32'(bus.avm_address), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_pass",    32'(pass), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_read_ts", read_ts, 32'd0);

    // Auto-check after reset release, zero wait
    reset = 1'b0;
    cyc(1);
    chk("auto_c1_read", 32'(bus.avm_read), 32'd1);
    chk("auto_c1_addr", 32'(bus.avm_address), 32'd0);
    chk("auto_c1_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("auto_c2_read", 32'(bus.avm_read), 32'd1);
    chk("auto_c2_addr", 32'(bus.avm_address), 32'd1);
    chk("auto_c2_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("auto_c3_read", 32'(bus.avm_read), 32'd0);
    chk("auto_c3_busy", 32'(busy), 32'd1);
    chk("auto_c3_done", 32'(done), 32'd0);
    cyc(1);
    chk("auto_c4_done",  32'(done), 32'd1);
    chk("auto_c4_pass",  32'(pass), 32'd1);
    chk("auto_c4_busy",  32'(busy), 32'd0);
    chk("auto_c4_id_ok", 32'(id_ok), 32'd1);
    chk("auto_c4_ts_ok", 32'(ts_ok), 32'd1);
    chk("auto_c4_rd_ts", read_ts, 32'd1512962994);
    cyc(1);
    chk("auto_hold_done", 32'(done), 32'd1);

    // Wrong timestamp; start in FIN restarts, start while busy is ignored
    ts_val = 32'd1512962995;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("ts_c1_done", 32'(done), 32'd0);
    chk("ts_c1_pass", 32'(pass), 32'd0);
    chk("ts_c1_busy", 32'(busy), 32'd1);
    chk("ts_c1_addr", 32'(bus.avm_address), 32'd0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("busy_start_addr", 32'(bus.avm_address), 32'd1);
    chk("busy_start_read", 32'(bus.avm_read), 32'd1);
    cyc(2);
    chk("ts_done",  32'(done), 32'd1);
    chk("ts_id_ok", 32'(id_ok), 32'd1);
    chk("ts_ts_ok", 32'(ts_ok), 32'd0);
    chk("ts_pass",  32'(pass), 32'd0);
    chk("ts_rd_ts", read_ts, 32'd1512962995);
    cyc(1);
    chk("ts_hold_done", 32'(done), 32'd1);
    chk("ts_hold_busy", 32'(busy), 32'd0);

    // Three stall cycles per read
    ts_val = 32'd1512962994;
    wait_n = 8'd3;
    start  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      start = 1'b0;
      chk("w3_id_addr", 32'(bus.avm_address), 32'd0);
      chk("w3_id_read", 32'(bus.avm_read), 32'd1);
    end
    for (int i = 5; i <= 8; i++) begin
      cyc(1);
      chk("w3_ts_addr", 32'(bus.avm_address), 32'd1);
      chk("w3_ts_read", 32'(bus.avm_read), 32'd1);
    end
    cyc(1);
    chk("w3_c9_done", 32'(done), 32'd0);
    chk("w3_c9_read", 32'(bus.avm_read), 32'd0);
    cyc(1);
    chk("w3_c10_done", 32'(done), 32'd1);
    chk("w3_c10_pass", 32'(pass), 32'd1);

    // Waitrequest stuck high: timeout after 5 cycles in RD_ID
    stuck = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    chk("to_c5_read", 32'(bus.avm_read), 32'd1);
    chk("to_c5_done", 32'(done), 32'd0);
    chk("to_c5_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("to_done",    32'(done), 32'd1);
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_pass",    32'(pass), 32'd0);
    chk("to_read",    32'(bus.avm_read), 32'd0);
    chk("to_busy",    32'(busy), 32'd0);
    chk("to_id_ok",   32'(id_ok), 32'd0);
    chk("to_ts_ok",   32'(ts_ok), 32'd0);

    // Four stalls per read equals the limit and must still complete
    stuck  = 1'b0;
    wait_n = 8'd4;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("w4_c1_timeout", 32'(timeout), 32'd0);
    cyc(10);
    chk("w4_c11_done", 32'(done), 32'd0);
    cyc(1);
    chk("w4_c12_done",    32'(done), 32'd1);
    chk("w4_c12_timeout", 32'(timeout), 32'd0);
    chk("w4_c12_pass",    32'(pass), 32'd1);

    // Reset during an RD_TS stall, then auto-check reruns
    wait_n = 8'd3;
    id_val = 32'h1234_5678;
    start  = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    chk("mid_rd_ts_addr", 32'(bus.avm_address), 32'd1);
    chk("mid_rd_id",      read_id, 32'h1234_5678);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_read",    32'(bus.avm_read), 32'd0);
    chk("mid_rst_addr",    32'(bus.avm_address), 32'd0);
    chk("mid_rst_busy",    32'(busy), 32'd0);
    chk("mid_rst_done",    32'(done), 32'd0);
    chk("mid_rst_pass",    32'(pass), 32'd0);
    chk("mid_rst_id_ok",   32'(id_ok), 32'd0);
    chk("mid_rst_ts_ok",   32'(ts_ok), 32'd0);
    chk("mid_rst_timeout", 32'(timeout), 32'd0);
    chk("mid_rst_read_id", read_id, 32'd0);
    chk("mid_rst_read_ts", read_ts, 32'd0);
    id_val = 32'd0;
    reset  = 1'b0;
    cyc(9);
    chk("rerun_c9_done", 32'(done), 32'd0);
    cyc(1);
    chk("rerun_done", 32'(done), 32'd1);
    chk("rerun_pass", 32'(pass), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'd0, system ID value the design must report.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'd1512962994, build timestamp the design must report.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535, maximum waitrequest cycles allowed per read.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle pulse that requests a re-check.
REQ-008 avm_address  output  1  word select: 0 = system ID, 1 = timestamp.
REQ-009 avm_read  output  1  Avalon-MM read strobe.
REQ-010 avm_readdata  input  32  read data from the sysid slave.
REQ-011 avm_waitrequest  input  1  slave stall; a read completes on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-012 busy  output  1  check in progress.
REQ-013 done  output  1  check finished; held until the next check starts.
REQ-014 pass  output  1  id_ok AND ts_ok AND NOT timeout; valid while done=1.
REQ-015 id_ok, ts_ok, timeout  output  1 each  per-field result flags.
REQ-016 read_id, read_ts  output  32 each  captured words.

Function
REQ-017 FSM states SHALL be: IDLE, RD_ID, RD_TS, CHECK, FIN.
REQ-018 In the first cycle after reset deasserts, the FSM SHALL leave IDLE for RD_ID without waiting for start (auto-check).
REQ-019 IDLE and FIN SHALL go to RD_ID on start=1, clearing done, pass, id_ok, ts_ok and timeout in the same edge.
REQ-020 RD_ID SHALL drive avm_read=1, avm_address=0; on completion it SHALL capture avm_readdata into read_id and go to RD_TS.
REQ-021 RD_TS SHALL drive avm_read=1, avm_address=1; on completion it SHALL capture avm_readdata into read_ts and go to CHECK.
REQ-022 avm_address SHALL stay stable while avm_read=1 and avm_waitrequest=1.
REQ-023 With zero waitrequest, RD_ID, RD_TS and CHECK SHALL each last exactly one cycle, so done rises 3 cycles after the start edge.
REQ-024 CHECK SHALL set id_ok = (read_id == EXPECTED_ID) and ts_ok = (read_ts == EXPECTED_TIMESTAMP), using a full 32-bit compare, then go to FIN.
REQ-025 FIN SHALL assert done=1 and busy=0 and hold all results.
REQ-026 A 16-bit wait counter SHALL clear on entry to each read state and increment on every cycle with avm_waitrequest=1.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES while waitrequest is still asserted, the FSM SHALL drop avm_read, set timeout=1, pass=0, id_ok=0 and ts_ok=0, and go to FIN.
REQ-028 busy SHALL be 1 in RD_ID, RD_TS and CHECK, and 0 otherwise.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 avm_read SHALL be 0 in IDLE, CHECK and FIN.

Reset
REQ-031 reset=1 SHALL force state to IDLE; set avm_read, busy, done, pass, id_ok, ts_ok and timeout to 0; set avm_address to 0; clear read_id, read_ts and the wait counter to 0.
REQ-032 reset asserted mid-read SHALL abort the transaction, with avm_read=0 on the following cycle; no partial result SHALL be retained.

Structure
REQ-033 The state enum, the word addresses (ID=0, TS=1) and the default expected values SHALL live in the shared package sysid_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-035 Slave with zero wait returning ID 0 and TS 1512962994; release reset -> avm_read pulses with address 0 then 1, done=1 and pass=1 at cycle 4, busy high for cycles 1-3.
REQ-036 Slave returns TS 1512962995 -> done=1, id_ok=1, ts_ok=0, pass=0, read_ts=1512962995.
REQ-037 Slave with 3 wait cycles on every read -> address held stable during stalls, done 9 cycles after start, pass=1.
REQ-038 TIMEOUT_CYCLES=4 with waitrequest stuck high -> timeout=1, pass=0, avm_read=0, done=1 after 5 cycles in RD_ID.
REQ-039 start pulsed while busy -> ignored; start pulsed in FIN -> done cleared next cycle and a new 2-read sequence runs.
REQ-040 reset asserted during RD_TS stall -> next cycle avm_read=0 and all outputs 0; after release the auto-check reruns and passes.
